// File: rtl/cpu_pkg.sv
// Shared control-word bit map, opcode encodings and fetch words for the
// microcoded instruction decoder.
package cpu_pkg;

  localparam int CW_BASE_W = 16;

  localparam int CW_STEP_RESET = 0;
  localparam int CW_J          = 1;
  localparam int CW_CO         = 2;
  localparam int CW_CE         = 3;
  localparam int CW_OI         = 4;
  localparam int CW_BI         = 5;
  localparam int CW_SU         = 6;
  localparam int CW_EO         = 7;
  localparam int CW_AO         = 8;
  localparam int CW_AI         = 9;
  localparam int CW_II         = 10;
  localparam int CW_IO         = 11;
  localparam int CW_RO         = 12;
  localparam int CW_RI         = 13;
  localparam int CW_MI         = 14;
  localparam int CW_HALT       = 15;

  // The instruction register's load/drive strobes are the II/IO lines.
  localparam int CW_INSTRUCTION_IN  = CW_II;
  localparam int CW_INSTRUCTION_OUT = CW_IO;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [CW_BASE_W-1:0] cw_bit(input int idx);
    cw_bit = CW_BASE_W'(1) << idx;
  endfunction

  localparam logic [CW_BASE_W-1:0] FETCH0 = cw_bit(CW_CO) | cw_bit(CW_MI);
  localparam logic [CW_BASE_W-1:0] FETCH1 = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: {opcode, step, flags} -> control word.
// Steps 0/1 are the common fetch; anything not listed ends the instruction.
module microcode_rom
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_W       = 3,
  parameter int FLAG_COUNT   = 2,
  parameter int CW_WIDTH     = 16
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [STEP_W-1:0]       step_i,
  input  logic [FLAG_COUNT-1:0]   flags_i,
  output logic [CW_WIDTH-1:0]     cw_o
);

  logic [CW_BASE_W-1:0] word;
  logic                 s2;
  logic                 s3;
  logic                 s4;

  assign s2 = (step_i == STEP_W'(2));
  assign s3 = (step_i == STEP_W'(3));
  assign s4 = (step_i == STEP_W'(4));

  always_comb begin
    word = cw_bit(CW_STEP_RESET);
    if (step_i == STEP_W'(0)) begin
      word = FETCH0;
    end else if (step_i == STEP_W'(1)) begin
      word = FETCH1;
    end else begin
      case (opcode_i)
        OPCODE_WIDTH'(OP_LDA): begin
          if (s2)      word = cw_bit(CW_IO) | cw_bit(CW_MI);
          else if (s3) word = cw_bit(CW_RO) | cw_bit(CW_AI) | cw_bit(CW_STEP_RESET);
        end
        OPCODE_WIDTH'(OP_ADD): begin
          if (s2)      word = cw_bit(CW_IO) | cw_bit(CW_MI);
          else if (s3) word = cw_bit(CW_RO) | cw_bit(CW_BI);
          else if (s4) word = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_STEP_RESET);
        end
        OPCODE_WIDTH'(OP_LDI): begin
          if (s2) word = cw_bit(CW_IO) | cw_bit(CW_AI) | cw_bit(CW_STEP_RESET);
        end
        OPCODE_WIDTH'(OP_JMP): begin
          if (s2) word = cw_bit(CW_IO) | cw_bit(CW_J);
        end
        // A failed condition falls through to the default early end.
        OPCODE_WIDTH'(OP_JC): begin
          if (s2 && flags_i[0]) word = cw_bit(CW_IO) | cw_bit(CW_J);
        end
        OPCODE_WIDTH'(OP_JZ): begin
          if (s2 && flags_i[1]) word = cw_bit(CW_IO) | cw_bit(CW_J);
        end
        OPCODE_WIDTH'(OP_OUT): begin
          if (s2) word = cw_bit(CW_AO) | cw_bit(CW_OI) | cw_bit(CW_STEP_RESET);
        end
        OPCODE_WIDTH'(OP_HLT): begin
          if (s2) word = cw_bit(CW_HALT);
        end
        default: word = cw_bit(CW_STEP_RESET);
      endcase
    end
  end

  assign cw_o = CW_WIDTH'(word);

endmodule

// File: rtl/microcoded_instruction_decoder.sv
// Instruction register, microstep counter and sticky HALT, with tri-state
// drivers onto the shared data bus and control-word lines.
module microcoded_instruction_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int STEPS        = 8,
  parameter int FLAG_COUNT   = 2,
  parameter int CW_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     clear_n,
  input  logic                     enable,
  input  logic [FLAG_COUNT-1:0]    flag_register,
  input  logic [DATA_WIDTH-1:0]    bus_in,
  output logic [DATA_WIDTH-1:0]    bus_out,
  input  logic [CW_WIDTH-1:0]      control_word_in,
  output logic [CW_WIDTH-1:0]      control_word_out,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     halted
);

  localparam int STEP_W    = $clog2(STEPS);
  localparam int OPERAND_W = DATA_WIDTH - OPCODE_WIDTH;

  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  halted_q, halted_d;
  logic [CW_WIDTH-1:0]   rom_cw;
  logic                  unused_cw;

  assign unused_cw = ^control_word_in;

  always_comb begin
    ir_d = ir_q;
    if (control_word_in[CW_INSTRUCTION_IN]) ir_d = bus_in;

    step_d = step_q;
    if (enable && !halted_q) begin
      if (control_word_in[CW_STEP_RESET])      step_d = '0;
      else if (step_q == STEP_W'(STEPS - 1))   step_d = '0;
      else                                     step_d = step_q + STEP_W'(1);
    end

    halted_d = halted_q | (enable & control_word_in[CW_HALT]);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      ir_q     <= '0;
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  microcode_rom #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .STEP_W      (STEP_W),
    .FLAG_COUNT  (FLAG_COUNT),
    .CW_WIDTH    (CW_WIDTH)
  ) u_rom (
    .opcode_i(ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]),
    .step_i  (step_q),
    .flags_i (flag_register),
    .cw_o    (rom_cw)
  );

  assign bus_out = control_word_in[CW_INSTRUCTION_OUT]
                   ? {{OPCODE_WIDTH{1'b0}}, ir_q[OPERAND_W-1:0]}
                   : {DATA_WIDTH{1'bz}};

  assign control_word_out = !enable  ? {CW_WIDTH{1'bz}} :
                            halted_q ? CW_WIDTH'(cw_bit(CW_HALT)) :
                                       rom_cw;

  assign step   = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_microcoded_instruction_decoder.sv
// Directed bench: the decoder sits on shared data/control nets together with
// a bench-side RAM driver and an external control-word driver.
module tb_microcoded_instruction_decoder;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        enable;
  logic [1:0]  flags;
  logic        ram_oe;
  logic [7:0]  ram_val;
  logic        ext_oe;
  logic [15:0] ext_cw;
  logic [2:0]  step;
  logic        halted;
  wire  [7:0]  data_bus;
  wire  [15:0] cw_bus;

  int n_total = 0;
  int n_pass  = 0;

  // Hand-encoded control words (CO=2 CE=3 BI=5 AI=9 II=10 IO=11 RO=12 MI=14 HLT=15 J=1 SR=0).
  localparam logic [15:0] W_FETCH0 = 16'h4004;
  localparam logic [15:0] W_FETCH1 = 16'h1408;
  localparam logic [15:0] W_LDI2   = 16'h0A01;
  localparam logic [15:0] W_SR     = 16'h0001;
  localparam logic [15:0] W_JUMP   = 16'h0802;
  localparam logic [15:0] W_HALT   = 16'h8000;
  localparam logic [15:0] W_ADD2   = 16'h4800;
  localparam logic [15:0] W_ADD3   = 16'h1020;
  localparam logic [15:0] W_II     = 16'h0400;
  localparam logic [15:0] W_IO     = 16'h0800;

  assign data_bus = ram_oe ? ram_val : 8'hzz;
  assign cw_bus   = ext_oe ? ext_cw  : 16'hzzzz;

  always #5 clk = ~clk;

  microcoded_instruction_decoder dut (
    .clk             (clk),
    .clear_n         (clear_n),
    .enable          (enable),
    .flag_register   (flags),
    .bus_in          (data_bus),
    .bus_out         (data_bus),
    .control_word_in (cw_bus),
    .control_word_out(cw_bus),
    .step            (step),
    .halted          (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps 0 and 1 of any instruction; RAM supplies the word during step 1.
  task automatic fetch(input string tag, input logic [7:0] instr);
    chk({tag, "_s0_cw"}, 32'(cw_bus), 32'(W_FETCH0));
    chk({tag, "_s0_step"}, 32'(step), 32'd0);
    tick();
    ram_val = instr;
    ram_oe  = 1'b1;
    #1;
    chk({tag, "_s1_cw"}, 32'(cw_bus), 32'(W_FETCH1));
    chk({tag, "_s1_bus"}, 32'(data_bus), 32'(instr));
    tick();
    ram_oe = 1'b0;
    #1;
    chk({tag, "_s2_step"}, 32'(step), 32'd2);
  endtask

  initial begin
    clear_n = 1'b0;
    enable  = 1'b1;
    flags   = 2'b00;
    ram_oe  = 1'b0;
    ram_val = 8'h00;
    ext_oe  = 1'b0;
    ext_cw  = 16'h0000;

    // Reset with enable high.
    tick();
    clear_n = 1'b1;
    #1;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cw", 32'(cw_bus), 32'(W_FETCH0));

    // External IR load while the decoder is disabled.
    enable  = 1'b0;
    ext_oe  = 1'b1;
    ext_cw  = W_II;
    ram_val = 8'h5A;
    ram_oe  = 1'b1;
    tick();
    chk("ext_cw_released", 32'(cw_bus), 32'(W_II));
    chk("ext_step_hold", 32'(step), 32'd0);
    ram_oe = 1'b0;
    ext_cw = W_IO;
    #1;
    chk("ext_ir_operand", 32'(data_bus), 32'h0A);
    ext_oe = 1'b0;
    enable = 1'b1;
    #1;

    // LDI 7.
    fetch("ldi", 8'h57);
    chk("ldi_s2_cw", 32'(cw_bus), 32'(W_LDI2));
    chk("ldi_s2_bus", 32'(data_bus), 32'h07);
    tick();
    chk("ldi_end_step", 32'(step), 32'd0);

    // JC, carry clear: no jump.
    flags = 2'b00;
    fetch("jc0", 8'h73);
    chk("jc0_s2_cw", 32'(cw_bus), 32'(W_SR));
    tick();
    chk("jc0_end_step", 32'(step), 32'd0);

    // JC, carry set: jump then end.
    flags = 2'b01;
    fetch("jc1", 8'h73);
    chk("jc1_s2_cw", 32'(cw_bus), 32'(W_JUMP));
    chk("jc1_s2_bus", 32'(data_bus), 32'h03);
    tick();
    chk("jc1_s3_cw", 32'(cw_bus), 32'(W_SR));
    tick();
    chk("jc1_end_step", 32'(step), 32'd0);

    // JZ sees only the carry flag set: no jump.
    fetch("jz_nc", 8'h84);
    chk("jz_nc_s2_cw", 32'(cw_bus), 32'(W_SR));
    tick();

    // JZ with zero set.
    flags = 2'b10;
    fetch("jz1", 8'h84);
    chk("jz1_s2_cw", 32'(cw_bus), 32'(W_JUMP));
    tick();
    tick();
    flags = 2'b00;

    // Undefined opcode behaves as NOP.
    fetch("undef", 8'h3C);
    chk("undef_s2_cw", 32'(cw_bus), 32'(W_SR));
    tick();
    chk("undef_end_step", 32'(step), 32'd0);

    // HLT: latches and freezes the step counter.
    fetch("hlt", 8'hF0);
    chk("hlt_s2_cw", 32'(cw_bus), 32'(W_HALT));
    chk("hlt_s2_halted", 32'(halted), 32'd0);
    tick();
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_step", 32'(step), 32'd3);
    for (int i = 0; i < 10; i++) tick();
    chk("hlt_hold_halted", 32'(halted), 32'd1);
    chk("hlt_hold_step", 32'(step), 32'd3);
    chk("hlt_hold_cw", 32'(cw_bus), 32'(W_HALT));
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    #1;
    chk("hlt_clr_halted", 32'(halted), 32'd0);
    chk("hlt_clr_step", 32'(step), 32'd0);
    chk("hlt_clr_cw", 32'(cw_bus), 32'(W_FETCH0));

    // ADD interrupted by reset at step 3.
    fetch("add", 8'h2C);
    chk("add_s2_cw", 32'(cw_bus), 32'(W_ADD2));
    chk("add_s2_bus", 32'(data_bus), 32'h0C);
    tick();
    chk("add_s3_step", 32'(step), 32'd3);
    chk("add_s3_cw", 32'(cw_bus), 32'(W_ADD3));
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    #1;
    chk("add_rst_step", 32'(step), 32'd0);
    enable = 1'b0;
    ext_oe = 1'b1;
    ext_cw = W_IO;
    #1;
    chk("add_rst_ir", 32'(data_bus), 32'h00);
    chk("add_rst_cw_released", 32'(cw_bus), 32'(W_IO));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
